// File: rtl/r200_hazard_ctrl_if.sv
// rtl/r200_hazard_ctrl_if.sv - decode-boundary hazard signals between r200 pipeline and hazard controller
interface r200_hazard_ctrl_if;
   logic       id_valid;
   logic [4:0] id_rs1addr;
   logic [4:0] id_rs2addr;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic [1:0] id_pcsel;
   logic [4:0] ex_rdaddr;
   logic       ex_regwr;
   logic       ex_memrd;
   logic [4:0] mem_rdaddr;
   logic       mem_regwr;
   logic       mem_busy;
   logic       pc_stall;
   logic       ifid_stall;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       pipe_freeze;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic [1:0] hz_state;

   // pipeline side: supplies stage information, consumes stall/flush/forward controls
   modport master (
      output id_valid, id_rs1addr, id_rs2addr, id_uses_rs1, id_uses_rs2, id_pcsel,
             ex_rdaddr, ex_regwr, ex_memrd, mem_rdaddr, mem_regwr, mem_busy,
      input  pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
             fwd_a, fwd_b, hz_state
   );

   // hazard controller side
   modport slave (
      input  id_valid, id_rs1addr, id_rs2addr, id_uses_rs1, id_uses_rs2, id_pcsel,
             ex_rdaddr, ex_regwr, ex_memrd, mem_rdaddr, mem_regwr, mem_busy,
      output pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
             fwd_a, fwd_b, hz_state
   );
endinterface

// File: rtl/r200_hazard_ctrl.sv
// rtl/r200_hazard_ctrl.sv - r200 load-use/redirect/memory-wait hazard controller; R200_HZ_PERFCNT_EN adds stall/flush counters
module r200_hazard_ctrl #(
   parameter int LDUSE_BUBBLES = 1,
   parameter int FWD_EN        = 1
) (
   input  logic                clk,
   input  logic                rst,
   r200_hazard_ctrl_if.slave   hz
`ifdef R200_HZ_PERFCNT_EN
   ,
   output logic [31:0]         stall_cnt,
   output logic [31:0]         flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      LDUSE = 2'd1,
      MWAIT = 2'd2
   } hz_state_t;

   // the cycle that detects the hazard is the first bubble, so LDUSE covers the rest
   localparam logic [1:0] CNT_RELOAD = 2'(LDUSE_BUBBLES - 1);

   hz_state_t  state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic [1:0] fwd_a_q, fwd_b_q, fwd_a_nxt, fwd_b_nxt;

   logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
   logic ldu, raw, haz, redir;
   logic pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;

   // x0 never matches, so it can neither stall nor forward
   assign rs1_ex  = hz.id_uses_rs1 && (hz.id_rs1addr != 5'd0) && (hz.id_rs1addr == hz.ex_rdaddr);
   assign rs2_ex  = hz.id_uses_rs2 && (hz.id_rs2addr != 5'd0) && (hz.id_rs2addr == hz.ex_rdaddr);
   assign rs1_mem = hz.id_uses_rs1 && (hz.id_rs1addr != 5'd0) && (hz.id_rs1addr == hz.mem_rdaddr);
   assign rs2_mem = hz.id_uses_rs2 && (hz.id_rs2addr != 5'd0) && (hz.id_rs2addr == hz.mem_rdaddr);

   assign ldu   = hz.id_valid && hz.ex_memrd && hz.ex_regwr && (rs1_ex || rs2_ex);
   assign raw   = hz.id_valid && ((hz.ex_regwr && (rs1_ex || rs2_ex)) ||
                                  (hz.mem_regwr && (rs1_mem || rs2_mem)));
   // without forwarding every RAW dependency must wait it out like a load-use
   assign haz   = (FWD_EN != 0) ? ldu : (ldu || raw);
   assign redir = hz.id_valid && (hz.id_pcsel != 2'd0);

   // state and bubble counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next state and stall/flush/bubble/freeze decode; priority mem_busy > hazard > redirect
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;
      if (!rst) begin
         case (state)
            LDUSE: begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_bubble = 1'b1;
               if (hz.mem_busy) begin
                  pipe_freeze = 1'b1;
               end else if (cnt <= 2'd1) begin
                  state_nxt = RUN;
                  cnt_nxt   = 2'd0;
               end else begin
                  cnt_nxt = cnt - 2'd1;
               end
            end
            default: begin
               // MWAIT with memory ready behaves exactly as RUN
               if (hz.mem_busy) begin
                  pipe_freeze = 1'b1;
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  state_nxt   = MWAIT;
               end else begin
                  state_nxt = RUN;
                  if (haz) begin
                     pc_stall    = 1'b1;
                     ifid_stall  = 1'b1;
                     idex_bubble = 1'b1;
                     if (LDUSE_BUBBLES > 1) begin
                        cnt_nxt   = CNT_RELOAD;
                        state_nxt = LDUSE;
                     end
                  end else if (redir) begin
                     ifid_flush = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // forwarding select for the instruction about to enter EX; EX result beats MEM result
   always_comb begin
      fwd_a_nxt = 2'd0;
      fwd_b_nxt = 2'd0;
      if ((FWD_EN != 0) && !idex_bubble) begin
         if (hz.ex_regwr && rs1_ex)         fwd_a_nxt = 2'd1;
         else if (hz.mem_regwr && rs1_mem) fwd_a_nxt = 2'd2;
         if (hz.ex_regwr && rs2_ex)         fwd_b_nxt = 2'd1;
         else if (hz.mem_regwr && rs2_mem) fwd_b_nxt = 2'd2;
      end
   end

   // forwarding registers advance with ID/EX and hold while the pipe is frozen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_a_q <= 2'd0;
         fwd_b_q <= 2'd0;
      end else if (!pipe_freeze) begin
         fwd_a_q <= fwd_a_nxt;
         fwd_b_q <= fwd_b_nxt;
      end
   end

`ifdef R200_HZ_PERFCNT_EN
   // free-running event counters, wrap at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if (pc_stall)   stall_cnt <= stall_cnt + 32'd1;
         if (ifid_flush) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

   assign hz.pc_stall    = pc_stall;
   assign hz.ifid_stall  = ifid_stall;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_bubble = idex_bubble;
   assign hz.pipe_freeze = pipe_freeze;
   assign hz.fwd_a       = fwd_a_q;
   assign hz.fwd_b       = fwd_b_q;
   assign hz.hz_state    = state;

endmodule

// File: tb/tb_r200_hazard_ctrl.sv
// tb/tb_r200_hazard_ctrl.sv - randomized bench for r200_hazard_ctrl against a cycle-count reference model
module tb_r200_hazard_ctrl;
   localparam int NB  = 2;
   localparam int FWD = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   r200_hazard_ctrl_if bus();
`ifdef R200_HZ_PERFCNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   r200_hazard_ctrl #(.LDUSE_BUBBLES(NB), .FWD_EN(FWD)) dut (
      .clk(clk),
      .rst(rst),
      .hz(bus)
`ifdef R200_HZ_PERFCNT_EN
      ,
      .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   // reference model: remaining bubble cycles, memory-wait flag, forward selects, event counts
   int m_left = 0;
   bit m_wait = 0;
   int m_fa = 0, m_fb = 0;
   int m_sc = 0, m_fc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit hit(input logic used, input logic [4:0] src, input logic [4:0] dst);
      return used && (src != 0) && (src == dst);
   endfunction

   function automatic int fsel(input bit ex_hit, input bit mem_hit);
      if (FWD == 0) return 0;
      if (ex_hit)   return 1;
      if (mem_hit)  return 2;
      return 0;
   endfunction

   // inputs are already applied at posedge+1; check mid-cycle, then advance the model across the edge
   task automatic cycle();
      bit a_ex, b_ex, a_mem, b_mem, ldu, raw, haz, rdr;
      int e_pc, e_if, e_fl, e_bub, e_frz, e_st;
      #3;
      a_ex  = hit(bus.id_uses_rs1, bus.id_rs1addr, bus.ex_rdaddr)  && bus.ex_regwr;
      b_ex  = hit(bus.id_uses_rs2, bus.id_rs2addr, bus.ex_rdaddr)  && bus.ex_regwr;
      a_mem = hit(bus.id_uses_rs1, bus.id_rs1addr, bus.mem_rdaddr) && bus.mem_regwr;
      b_mem = hit(bus.id_uses_rs2, bus.id_rs2addr, bus.mem_rdaddr) && bus.mem_regwr;
      ldu   = bus.id_valid && bus.ex_memrd && (a_ex || b_ex);
      raw   = bus.id_valid && (a_ex || b_ex || a_mem || b_mem);
      haz   = (FWD != 0) ? ldu : raw;
      rdr   = bus.id_valid && (bus.id_pcsel != 0);
      e_pc = 0; e_if = 0; e_fl = 0; e_bub = 0; e_frz = 0; e_st = 0;
      if (rst) begin
         m_left = 0; m_wait = 0; m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
      end else if (m_left > 0) begin
         e_st = 1; e_pc = 1; e_if = 1; e_bub = 1; e_frz = bus.mem_busy;
      end else begin
         e_st = m_wait ? 2 : 0;
         if (bus.mem_busy) begin
            e_frz = 1; e_pc = 1; e_if = 1;
         end else if (haz) begin
            e_pc = 1; e_if = 1; e_bub = 1;
         end else if (rdr) begin
            e_fl = 1;
         end
      end
      chk("pc_stall",    bus.pc_stall,    e_pc);
      chk("ifid_stall",  bus.ifid_stall,  e_if);
      chk("ifid_flush",  bus.ifid_flush,  e_fl);
      chk("idex_bubble", bus.idex_bubble, e_bub);
      chk("pipe_freeze", bus.pipe_freeze, e_frz);
      chk("hz_state",    bus.hz_state,    e_st);
      chk("fwd_a",       bus.fwd_a,       m_fa);
      chk("fwd_b",       bus.fwd_b,       m_fb);
`ifdef R200_HZ_PERFCNT_EN
      chk("stall_cnt",   stall_cnt,       m_sc);
      chk("flush_cnt",   flush_cnt,       m_fc);
`endif
      if (!rst) begin
         m_sc += e_pc;
         m_fc += e_fl;
         if (!e_frz) begin
            m_fa = e_bub ? 0 : fsel(a_ex, a_mem);
            m_fb = e_bub ? 0 : fsel(b_ex, b_mem);
         end
         if (m_left > 0) begin
            if (!bus.mem_busy) m_left--;
         end else if (bus.mem_busy) begin
            m_wait = 1;
         end else begin
            m_wait = 0;
            if (haz) m_left = NB - 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic [1:0] pcs,
                         input logic [4:0] exrd, input logic exwr, input logic exmr,
                         input logic [4:0] memrd, input logic memwr, input logic busy);
      bus.id_valid = v;     bus.id_rs1addr = r1;  bus.id_rs2addr = r2;
      bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2; bus.id_pcsel = pcs;
      bus.ex_rdaddr = exrd; bus.ex_regwr = exwr;  bus.ex_memrd = exmr;
      bus.mem_rdaddr = memrd; bus.mem_regwr = memwr; bus.mem_busy = busy;
   endtask

   task automatic rand_in();
      bus.id_valid    = ($urandom_range(0, 7) != 0);
      bus.id_rs1addr  = 5'($urandom_range(0, 3));
      bus.id_rs2addr  = 5'($urandom_range(0, 3));
      bus.id_uses_rs1 = ($urandom_range(0, 3) != 0);
      bus.id_uses_rs2 = ($urandom_range(0, 1) != 0);
      bus.id_pcsel    = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bus.ex_rdaddr   = 5'($urandom_range(0, 3));
      bus.ex_regwr    = ($urandom_range(0, 1) != 0);
      bus.ex_memrd    = ($urandom_range(0, 2) == 0);
      bus.mem_rdaddr  = 5'($urandom_range(0, 3));
      bus.mem_regwr   = ($urandom_range(0, 1) != 0);
      bus.mem_busy    = ($urandom_range(0, 6) == 0);
      rst             = ($urandom_range(0, 99) == 0);
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      cycle();
      cycle();
      rst = 1'b0;

      // load-use on rs1 = x5 with two bubbles
      set_in(1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0);
      cycle();
      set_in(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      cycle();

      // forwarding: EX beats MEM, MEM only, x0
      set_in(1, 0, 7, 0, 1, 0, 7, 1, 0, 7, 1, 0);
      cycle();
      set_in(1, 0, 7, 0, 1, 0, 3, 1, 0, 7, 1, 0);
      cycle();
      set_in(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0);
      cycle();
      set_in(1, 0, 7, 0, 1, 0, 3, 1, 0, 7, 1, 0);
      cycle();

      // redirect alone, then redirect held behind a load-use
      set_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      cycle();
      set_in(1, 9, 0, 1, 0, 1, 9, 1, 1, 0, 0, 0);
      cycle();
      set_in(1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      cycle();
      cycle();

      // establish fwd_b=1, then memory busy three cycles
      set_in(1, 0, 4, 0, 1, 0, 4, 1, 0, 0, 0, 0);
      cycle();
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (3) cycle();
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();

      // asynchronous reset while in LDUSE
      set_in(1, 6, 0, 1, 0, 0, 6, 1, 1, 0, 0, 0);
      cycle();
      chk("st_before_rst", bus.hz_state, 1);
      #2;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();

      for (int i = 0; i < 3000; i++) begin
         rand_in();
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/r200_hazard_ctrl.md
Name: r200_hazard_ctrl

Overview:
Pipeline hazard controller for the r200 core. It sequences the fetch/decode and decode/execute boundary around the instruction decode stage.
- Detects load-use hazards and inserts bubbles.
- Flushes wrong-path fetches on branch/jump redirects.
- Freezes the pipe while data memory is busy.
- Produces registered operand-forwarding selects for the execute stage.

Parameters:
LDUSE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
FWD_EN, 1, 1 = forwarding selects computed; 0 = fwd_a/fwd_b tied 0 and every RAW hazard stalls like a load-use.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  decode stage holds a valid instruction
id_rs1addr  in  5  rs1 address of decode instruction
id_rs2addr  in  5  rs2 address (post rs2addrsel mux)
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
id_pcsel  in  2  decoder pcsel; nonzero = redirect
ex_rdaddr  in  5  execute stage destination
ex_regwr  in  1  execute stage writes a register
ex_memrd  in  1  execute stage is a load
mem_rdaddr  in  5  memory stage destination
mem_regwr  in  1  memory stage writes a register
mem_busy  in  1  data memory not ready this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
ifid_flush  out  1  load NOP into IF/ID
idex_bubble  out  1  load NOP into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
fwd_a  out  2  EX operand-1 source: 0 regfile, 1 MEM stage, 2 WB stage
fwd_b  out  2  EX operand-2 source, same encoding
hz_state  out  2  current FSM state

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: hz_state=RUN, bubble counter=0, fwd_a=fwd_b=0. While rst is high, all combinational stall/flush/bubble/freeze outputs are 0.
- Hazard match rule: the source is used, the source address is nonzero, and the address equals the destination. Register x0 never causes a hazard or a forward.
- Load-use hazard (ldu): id_valid & ex_memrd & ex_regwr & (rs1 or rs2 matches ex_rdaddr).
- FWD_EN=0: raw = id_valid & (match against ex_rdaddr with ex_regwr, or against mem_rdaddr with mem_regwr). raw is treated exactly like ldu.
- Redirect (rd): id_valid & id_pcsel!=0.
- States: RUN=0, LDUSE=1, MWAIT=2.
- Priority within a cycle: mem_busy > ldu > rd.
- RUN, mem_busy=1:
  - pipe_freeze=pc_stall=ifid_stall=1.
  - Next state MWAIT. The pending hazard is re-evaluated after the wait.
- RUN, ldu=1:
  - pc_stall=ifid_stall=idex_bubble=1 this cycle.
  - If LDUSE_BUBBLES>1: counter <= LDUSE_BUBBLES-1, next state LDUSE. Otherwise stay RUN.
- RUN, rd=1 and no ldu: ifid_flush=1 in the same cycle; stay RUN. A redirect held by a load-use stall flushes only once the stall clears.
- LDUSE:
  - pc_stall=ifid_stall=idex_bubble=1; counter decrements.
  - Return to RUN when the counter reaches 1 in the current cycle.
  - mem_busy in LDUSE asserts pipe_freeze additionally. The counter holds and the state stays LDUSE.
- MWAIT: same outputs as RUN with mem_busy. Return to RUN on the first cycle mem_busy=0; that cycle's outputs are evaluated as RUN.
- Forwarding registers update at posedge when pipe_freeze=0:
  - If idex_bubble=1: fwd <= 0.
  - Else fwd_a <= 1 if ex_regwr & rs1 matches ex_rdaddr; else 2 if mem_regwr & rs1 matches mem_rdaddr; else 0. fwd_b uses rs2 the same way.
  - EX match beats MEM match. Holds when pipe_freeze=1.
- Reset asserted mid-LDUSE or mid-MWAIT returns to RUN immediately; the counter clears.

Optional Feature:
R200_HZ_PERFCNT_EN:
- When defined, adds two outputs: stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle pc_stall=1.
  - flush_cnt increments each cycle ifid_flush=1.
  - Both wrap at 2^32, reset to 0, and are frozen while rst is high.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- ex_memrd=1, ex_regwr=1, ex_rdaddr=5, id_rs1addr=5, id_uses_rs1=1, LDUSE_BUBBLES=2 -> pc_stall/idex_bubble high 2 cycles; hz_state RUN,LDUSE,RUN; fwd_a=0 after bubbles.
- ex_regwr=1, ex_rdaddr=7, mem_regwr=1, mem_rdaddr=7, id_rs2addr=7 (no load) -> no stall; next cycle fwd_b=1. Repeat with only mem match -> fwd_b=2. Repeat with addr 0 -> fwd_b=0.
- id_pcsel=2'b01, id_valid=1, no hazard -> ifid_flush=1 same cycle, no pc_stall. Combined with ldu -> stall first, then flush on the following cycle.
- mem_busy high 3 cycles during RUN -> pipe_freeze high 3 cycles, fwd regs unchanged, hz_state=MWAIT, then RUN.
- rst pulsed while hz_state=LDUSE -> hz_state=0 and all outputs 0 immediately (asynchronous).
- With R200_HZ_PERFCNT_EN: 2 load-use stalls + 1 flush -> stall_cnt=2, flush_cnt=1.
